// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter: shares an 8-cycle-slot SDRAM controller between
// three requesters (p0 video, p1 CPU, p2 ROM/loader).
//
// Ports:
//   clk, reset_n        - system clock, async active-low reset
//   mem_sync            - slot strobe to controller sync (high s=0..3)
//   mem_addr/din/ds     - controller address, write data, byte strobes
//   mem_oe / mem_we     - controller read / write request, held per slot
//   mem_dout            - controller read data
//   pN_req/we/addr/     - requester N (0..2) request bundle; req held
//   pN_wdata/pN_ds        high until pN_ack
//   pN_ack              - one-cycle completion pulse to requester N
//   rdata               - read data, valid in the ack cycle
//
// Build option: define REFRESH_EN to force an idle (auto-refresh) slot
// after REFRESH_SLOTS consecutive granted slots.

module sdram_slot_arbiter #(
   parameter int AW            = 24,
   parameter int DOUT_CYCLE    = 7,
   parameter int REFRESH_SLOTS = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   output logic          mem_sync,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_din,
   output logic [1:0]    mem_ds,
   output logic          mem_oe,
   output logic          mem_we,
   input  logic [15:0]   mem_dout,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [15:0]   p0_wdata,
   input  logic [1:0]    p0_ds,
   output logic          p0_ack,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [15:0]   p1_wdata,
   input  logic [1:0]    p1_ds,
   output logic          p1_ack,
   input  logic          p2_req,
   input  logic          p2_we,
   input  logic [AW-1:0] p2_addr,
   input  logic [15:0]   p2_wdata,
   input  logic [1:0]    p2_ds,
   output logic          p2_ack,
   output logic [15:0]   rdata
);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_P0   = 2'd1,
      GNT_P1   = 2'd2,
      GNT_P2   = 2'd3
   } gnt_e;

   localparam logic [2:0] LP_DOUT = 3'(DOUT_CYCLE);

   logic [2:0]    r_s;
   logic          r_started;
   logic          r_sync;
   gnt_e          r_gnt;
   logic          r_oe;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [15:0]   r_din;
   logic [1:0]    r_ds;
   logic [15:0]   r_rdata;
   logic [2:0]    r_ack;

   logic [2:0]    w_s_nx;
   logic          w_sync_nx;
   logic          w_slot_end;
   logic          w_cap;
   logic          w_force_idle;
   logic [2:0]    w_req;
   logic [2:0]    w_gnt_oh;
   logic [2:0]    w_cand;
   logic [2:0]    w_pick;
   gnt_e          w_gnt_nx;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [15:0]   w_sel_din;
   logic [1:0]    w_sel_ds;

   assign w_s_nx     = r_s + 3'd1;
   assign w_slot_end = (r_s == 3'd7);
   assign w_cap      = (r_s == LP_DOUT);

   // sync stays low until the first arbitration edge so the
   // controller never sees a slot start before a grant exists
   assign w_sync_nx = (r_started | w_slot_end) & ~w_s_nx[2];

   assign w_req    = {p2_req, p1_req, p0_req};
   assign w_gnt_oh = {r_gnt == GNT_P2,
                      r_gnt == GNT_P1,
                      r_gnt == GNT_P0};

   // the port owning the ending slot still has req high for
   // the access being acked, so it sits this boundary out
   assign w_cand = w_req & ~w_gnt_oh;

   assign w_pick[0] = w_cand[0] & ~w_force_idle;
   assign w_pick[1] = w_cand[1] & ~w_cand[0] & ~w_force_idle;
   assign w_pick[2] = w_cand[2] & ~w_cand[1] & ~w_cand[0]
                    & ~w_force_idle;

`ifdef REFRESH_EN
   localparam int RW = $clog2(REFRESH_SLOTS + 1);

   logic [RW-1:0] r_ref;

   assign w_force_idle = (r_ref == RW'(REFRESH_SLOTS));

   // counts consecutive granted slots; any idle slot clears it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ref <= '0;
      end else if (w_slot_end) begin
         if (w_gnt_nx == GNT_NONE)
            r_ref <= '0;
         else
            r_ref <= r_ref + 1'b1;
      end
   end
`else
   // a zero-length refresh window would mean permanent idle,
   // the same as the counter build; otherwise never forced
   assign w_force_idle = (REFRESH_SLOTS < 1);
`endif

   always_comb begin
      w_gnt_nx   = GNT_NONE;
      w_sel_we   = 1'b0;
      w_sel_addr = '0;
      w_sel_din  = '0;
      w_sel_ds   = '0;
      unique case (1'b1)
         w_pick[0]: begin
            w_gnt_nx   = GNT_P0;
            w_sel_we   = p0_we;
            w_sel_addr = p0_addr;
            w_sel_din  = p0_wdata;
            w_sel_ds   = p0_ds;
         end
         w_pick[1]: begin
            w_gnt_nx   = GNT_P1;
            w_sel_we   = p1_we;
            w_sel_addr = p1_addr;
            w_sel_din  = p1_wdata;
            w_sel_ds   = p1_ds;
         end
         w_pick[2]: begin
            w_gnt_nx   = GNT_P2;
            w_sel_we   = p2_we;
            w_sel_addr = p2_addr;
            w_sel_din  = p2_wdata;
            w_sel_ds   = p2_ds;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s       <= 3'd0;
         r_started <= 1'b0;
         r_sync    <= 1'b0;
         r_gnt     <= GNT_NONE;
         r_oe      <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_din     <= '0;
         r_ds      <= '0;
         r_rdata   <= '0;
         r_ack     <= '0;
      end else begin
         r_s       <= w_s_nx;
         r_sync    <= w_sync_nx;
         r_started <= r_started | w_slot_end;
         // ack uses the grant of the slot being completed, even
         // when the same edge also installs the next grant
         r_ack <= w_cap ? w_gnt_oh : 3'b000;
         if (w_cap && r_oe)
            r_rdata <= mem_dout;
         if (w_slot_end) begin
            r_gnt  <= w_gnt_nx;
            r_oe   <= (w_gnt_nx != GNT_NONE) & ~w_sel_we;
            r_we   <= (w_gnt_nx != GNT_NONE) & w_sel_we;
            r_addr <= w_sel_addr;
            r_din  <= w_sel_din;
            r_ds   <= w_sel_ds;
         end
      end
   end

   assign mem_sync = r_sync;
   assign mem_addr = r_addr;
   assign mem_din  = r_din;
   assign mem_ds   = r_ds;
   assign mem_oe   = r_oe;
   assign mem_we   = r_we;
   assign p0_ack   = r_ack[0];
   assign p1_ack   = r_ack[1];
   assign p2_ack   = r_ack[2];
   assign rdata    = r_rdata;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// tb_sdram_slot_arbiter: random requesters against a slot-level
// reference model of sdram_slot_arbiter.

module tb_sdram_slot_arbiter;

   localparam int AW = 24;
   localparam int RS = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [15:0]   mem_dout = 16'h0;
   logic [2:0]    req = '0;
   logic [2:0]    we = '0;
   logic [AW-1:0] addr [3];
   logic [15:0]   wdata [3];
   logic [1:0]    ds [3];

   wire          mem_sync, mem_oe, mem_we;
   wire [AW-1:0] mem_addr;
   wire [15:0]   mem_din, rdata;
   wire [1:0]    mem_ds;
   wire [2:0]    ack;

   int total = 0;
   int bad = 0;

   // reference model state, slot level
   int            m_ph = 0;
   int            m_g = -1;
   int            m_ack = -1;
   int            m_ref = 0;
   bit            m_started = 0;
   bit            m_zero = 1;
   logic          m_sync = 1'b0;
   logic          m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [15:0]   m_din = '0;
   logic [1:0]    m_ds = '0;
   logic [15:0]   m_rdata = '0;

   bit          fix_en = 0;
   logic [15:0] fix_val = 16'h0;
   int          p_acks [3];

   always #5 clk = ~clk;

   sdram_slot_arbiter #(
      .AW(AW), .DOUT_CYCLE(7), .REFRESH_SLOTS(RS)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_sync(mem_sync), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_ds(mem_ds),
      .mem_oe(mem_oe), .mem_we(mem_we), .mem_dout(mem_dout),
      .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]),
      .p0_wdata(wdata[0]), .p0_ds(ds[0]), .p0_ack(ack[0]),
      .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]),
      .p1_wdata(wdata[1]), .p1_ds(ds[1]), .p1_ack(ack[1]),
      .p2_req(req[2]), .p2_we(we[2]), .p2_addr(addr[2]),
      .p2_wdata(wdata[2]), .p2_ds(ds[2]), .p2_ack(ack[2]),
      .rdata(rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("sync", 32'(mem_sync), 32'(m_sync));
      chk("oe", 32'(mem_oe), 32'(m_g >= 0 && !m_we));
      chk("we", 32'(mem_we), 32'(m_g >= 0 && m_we));
      chk("ack", 32'(ack), 32'(m_ack >= 0 ? (1 << m_ack) : 0));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      if (m_g >= 0 || m_zero) begin
         chk("addr", 32'(mem_addr), 32'(m_addr));
         chk("din", 32'(mem_din), 32'(m_din));
         chk("ds", 32'(mem_ds), 32'(m_ds));
      end
      for (int i = 0; i < 3; i++)
         if (ack[i]) p_acks[i]++;
   endtask

   // predicts the DUT state after the coming rising edge
   task automatic model_edge();
      int pick;
      if (!reset_n) begin
         m_ph = 0; m_g = -1; m_ack = -1; m_ref = 0;
         m_started = 0; m_zero = 1; m_sync = 1'b0;
         m_we = 1'b0; m_addr = '0; m_din = '0; m_ds = '0;
         m_rdata = '0;
         return;
      end
      m_ack = -1;
      if (m_ph % 8 == 7) begin
         if (m_g >= 0) begin
            if (!m_we) m_rdata = mem_dout;
            m_ack = m_g;
         end
         pick = -1;
         for (int i = 2; i >= 0; i--)
            if (req[i] && i != m_g) pick = i;
`ifdef REFRESH_EN
         if (m_ref == RS) pick = -1;
`endif
         if (pick < 0) begin
            m_g = -1;
            m_ref = 0;
         end else begin
            m_g = pick;
            m_we = we[pick];
            m_addr = addr[pick];
            m_din = wdata[pick];
            m_ds = ds[pick];
            m_ref++;
         end
         m_started = 1;
         m_zero = 0;
      end
      m_ph++;
      m_sync = m_started && (m_ph % 8) < 4;
   endtask

   task automatic new_req(input int i);
      we[i] = 1'($urandom_range(0, 1));
      addr[i] = AW'($urandom);
      wdata[i] = 16'($urandom);
      ds[i] = 2'($urandom_range(1, 3));
   endtask

   task automatic stim(input int sp, input int kp);
      for (int i = 0; i < 3; i++) begin
         if (req[i]) begin
            if (m_ack == i) begin
               if ($urandom_range(0, 99) < kp) new_req(i);
               else req[i] = 1'b0;
            end else if (m_g == i && $urandom_range(0, 3) == 0) begin
               addr[i] = AW'($urandom);
               wdata[i] = 16'($urandom);
            end
         end else if ($urandom_range(0, 99) < sp) begin
            req[i] = 1'b1;
            new_req(i);
         end
      end
      mem_dout = fix_en ? fix_val : 16'($urandom);
   endtask

   task automatic tick_a();
      @(negedge clk);
      check_all();
   endtask

   task automatic tick_b(input int sp, input int kp, input bit rn);
      stim(sp, kp);
      reset_n = rn;
      model_edge();
   endtask

   task automatic cyc(input int sp, input int kp, input bit rn);
      tick_a();
      tick_b(sp, kp, rn);
   endtask

   task automatic clr_acks();
      for (int i = 0; i < 3; i++) p_acks[i] = 0;
   endtask

   initial begin
      int n;
      int rc;
      int sp_t [6] = '{30, 80, 5, 100, 50, 20};
      int kp_t [6] = '{50, 80, 20, 100, 0, 90};
      for (int i = 0; i < 3; i++) begin
         addr[i] = '0; wdata[i] = '0; ds[i] = '0;
      end
      clr_acks();

      req[0] = 1'b1;
      new_req(0);
      repeat (5) cyc(0, 100, 1'b0);
      repeat (24) cyc(0, 0, 1'b1);
      chk("rst_p0_acks", 32'(p_acks[0]), 32'd1);

      tick_a();
      clr_acks();
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 24'h012345;
      fix_en = 1; fix_val = 16'hBEEF;
      tick_b(0, 0, 1'b1);
      repeat (23) cyc(0, 0, 1'b1);
      chk("rd_data", 32'(rdata), 32'h0000BEEF);
      chk("rd_acks", 32'(p_acks[1]), 32'd1);

      tick_a();
      clr_acks();
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 24'h000100;
      wdata[2] = 16'h55AA; ds[2] = 2'b01;
      fix_val = 16'h1234;
      tick_b(0, 0, 1'b1);
      repeat (23) cyc(0, 0, 1'b1);
      chk("wr_rdata_kept", 32'(rdata), 32'h0000BEEF);
      chk("wr_acks", 32'(p_acks[2]), 32'd1);
      fix_en = 0;

      repeat (24) cyc(0, 0, 1'b1);

      tick_a();
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b1;
         new_req(i);
      end
      tick_b(100, 100, 1'b1);
      repeat (32) cyc(100, 100, 1'b1);
      clr_acks();
      repeat (160) cyc(100, 100, 1'b1);
      chk("sat_p2_starved", 32'(p_acks[2]), 32'd0);
`ifdef REFRESH_EN
      chk("sat_p0", 32'(p_acks[0]), 32'd8);
      chk("sat_p1", 32'(p_acks[1]), 32'd8);
`else
      chk("sat_p0", 32'(p_acks[0]), 32'd10);
      chk("sat_p1", 32'(p_acks[1]), 32'd10);
`endif

      tick_a();
      req = '0;
      tick_b(0, 0, 1'b1);
      repeat (24) cyc(0, 0, 1'b1);
      tick_a();
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 24'h0ABCDE;
      tick_b(0, 0, 1'b1);
      n = 0;
      while (!(m_g == 1 && m_ph % 8 == 3) && n < 40) begin
         cyc(0, 0, 1'b1);
         n++;
      end
      chk("rst_wait_gnt", 32'(n < 40), 32'd1);
      clr_acks();
      repeat (3) cyc(0, 0, 1'b0);
      chk("rst_no_ack", 32'(p_acks[1]), 32'd0);
      repeat (24) cyc(0, 0, 1'b1);
      chk("rst_reack", 32'(p_acks[1]), 32'd1);

      rc = 0;
      for (int p = 0; p < 6; p++) begin
         for (int k = 0; k < 600; k++) begin
            bit rn;
            rn = 1'b1;
            if (rc > 0) begin
               rn = 1'b0;
               rc--;
            end else if ($urandom_range(0, 299) == 0) begin
               rc = $urandom_range(0, 3);
               rn = 1'b0;
            end
            cyc(sp_t[p], kp_t[p], rn);
         end
      end
      repeat (4) cyc(0, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
